pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
// - Responder end of the 256-bit physical-memory line interface driven by the L1 cache.
// - Accepts one line read or line write at a time and answers with a single-cycle pmem_resp
//   after a fixed latency.
// - Backed by an internal line array; serves as the pmem model for cache benches and as the
//   seed of the later memory controller.
// PARAMETERS
// - DEPTH    default 256  lines in array; power of 2, >=2; index width IW = $clog2(DEPTH)
// - LATENCY  default 4    cycles from request acceptance to pmem_resp; >=1
// PORTS
// - clk          in   1    clock; all logic on rising edge
// - rst          in   1    synchronous, active-high reset
// - pmem_address in   32   byte address of line; [4:0] ignored, index = [5 +: IW], upper bits ignored (alias)
// - pmem_read    in   1    line read request, level, held by initiator until pmem_resp
// - pmem_write   in   1    line write request, level, held by initiator until pmem_resp
// - pmem_wdata   in   256  write line data
// - pmem_resp    out  1    one-cycle completion pulse
// - pmem_rdata   out  256  read line data, valid in pmem_resp cycle
// - proto_err    out  1    sticky protocol error (only with PMEM_PROTOCOL_CHECK_EN)
// BEHAVIOUR
// - Reset: state=IDLE, counter=0, pmem_resp=0, pmem_rdata=0, proto_err=0.
// - Reset does not modify the array; array is zero at time 0.
// - FSM IDLE -> BUSY -> RESP -> IDLE.
// - IDLE: if pmem_read|pmem_write, capture op, index, wdata.
//   - Go to RESP if LATENCY==1, else go to BUSY with counter=LATENCY-1.
//   - Both asserted: read wins, write discarded.
// - BUSY: decrement counter; at 1 go to RESP. Inputs ignored; captured values are used.
// - Entry to RESP (same edge):
//   - Read: pmem_rdata <= array[index].
//   - Write: array[index] <= captured wdata.
// - RESP: pmem_resp=1 for exactly this cycle; next state IDLE unconditionally.
// - Latency: request first sampled in IDLE at cycle 0 -> pmem_resp high in cycle LATENCY.
// - Back-to-back: request still high in the cycle after RESP is a new request. Min spacing of
//   resp pulses is LATENCY+1 cycles.
// - pmem_rdata holds its value until the next read reaches RESP. Writes do not change it.
// - Write then read to same index: the read returns the newly written line.
// - Reset mid-BUSY: operation aborted, no array write, pmem_resp=0 from next cycle.
// - Reset in the RESP cycle: the write has already committed; the resp pulse still ends that cycle.
// - Index wrap: address 32'h0000_2000 with DEPTH=256 aliases line 0.
// CONFIGURATION
// - PMEM_PROTOCOL_CHECK_EN defined: proto_err sets (sticky until rst) when any of:
//   - pmem_read & pmem_write both high in the cycle sampled in IDLE;
//   - in BUSY/RESP, the captured request bit drops low;
//   - in BUSY/RESP, pmem_address[31:5] differs from the captured value.
//   - Functional behaviour is otherwise identical.
// - Not defined: proto_err tied 0; no check logic.
// TESTING
// - Write 0xA5..A5 to 0x0000_0040, then read it (LATENCY=4) -> each pmem_resp exactly 4 cycles
//   after request; rdata=0xA5..A5.
// - Read an unwritten line 0x0000_0100 after reset -> rdata=0.
// - Read with LATENCY=1 -> resp the next cycle.
// - Initiator keeps pmem_read high after resp -> second resp exactly LATENCY+1 cycles after the first.
// - rst at BUSY count 2 of a write to 0x80 -> no resp; later read of 0x80 returns the old data.
// - pmem_read & pmem_write together -> read performed, array unchanged.
//   - Check EN: proto_err=1.
//   - Check not EN: proto_err=0.
// - Write 0x0000_2000, read 0x0000_0000 (DEPTH=256) -> same data (alias).

Source files
------------

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: responder side of the 256-bit line interface used by the L1 cache.
// Serves one line read or line write at a time from an internal line array and answers
// with a one-cycle pmem_resp a fixed LATENCY cycles after the request is accepted.
//
// Handshake: pmem_read / pmem_write are levels that the initiator raises and holds (with a
// stable address) until it sees pmem_resp high; a request seen in IDLE is accepted on that
// edge, pmem_resp is high for exactly one cycle, and a request still high in the cycle after
// the pulse counts as a new request.
//
// Optional build macro: PMEM_PROTOCOL_CHECK_EN enables the sticky proto_err monitor.
// Without it proto_err is tied low and no checking logic exists.
// dbg_state exposes the FSM state (0 IDLE, 1 BUSY, 2 RESP).
module pmem_line_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  pmem_address,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         proto_err,
    output logic [1:0]   dbg_state
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // Request captured at acceptance; used for the whole BUSY phase.
    logic          op_read;
    logic [IW-1:0] op_idx;
    logic [255:0]  op_wdata;

    // Array access performed on the edge that enters RESP.
    logic          go_resp;
    logic          acc_read;
    logic [IW-1:0] acc_idx;
    logic [255:0]  acc_wdata;

    // Line array; zero at power-up, never touched by reset.
    logic [255:0]  mem [DEPTH] = '{default: '0};

    // Offset bits and upper alias bits carry no meaning for the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[4:0], pmem_address[31:5+IW]};

    assign pmem_resp = (state == RESP);
    assign dbg_state = state;

    // Select the operation that enters RESP on this edge: live inputs when LATENCY is 1,
    // otherwise the captured request at the end of the BUSY countdown.
    always_comb begin
        go_resp   = 1'b0;
        acc_read  = 1'b0;
        acc_idx   = '0;
        acc_wdata = '0;
        case (state)
            IDLE: begin
                if (LATENCY == 1 && (pmem_read || pmem_write)) begin
                    go_resp   = 1'b1;
                    acc_read  = pmem_read;
                    acc_idx   = pmem_address[5 +: IW];
                    acc_wdata = pmem_wdata;
                end
            end
            BUSY: begin
                if (cnt == CW'(1)) begin
                    go_resp   = 1'b1;
                    acc_read  = op_read;
                    acc_idx   = op_idx;
                    acc_wdata = op_wdata;
                end
            end
            default: ;
        endcase
    end

    // FSM, latency counter and read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pmem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pmem_read || pmem_write) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (go_resp && acc_read) begin
                pmem_rdata <= mem[acc_idx];
            end
        end
    end

    // Capture the request when it is accepted in IDLE; a simultaneous write loses to the read.
    always_ff @(posedge clk) begin
        if (state == IDLE && (pmem_read || pmem_write)) begin
            op_read  <= pmem_read;
            op_idx   <= pmem_address[5 +: IW];
            op_wdata <= pmem_wdata;
        end
    end

    // Commit a write on entry to RESP; a reset on that edge aborts it.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && !acc_read) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic [26:0] op_tag;
    logic        viol;

    // Remember the line address of the accepted request for the stability check.
    always_ff @(posedge clk) begin
        if (state == IDLE && (pmem_read || pmem_write)) begin
            op_tag <= pmem_address[31:5];
        end
    end

    // Flag conflicting requests, dropped requests and address changes while in flight.
    always_comb begin
        viol = 1'b0;
        if (state == IDLE) begin
            viol = pmem_read && pmem_write;
        end else begin
            viol = (op_read ? !pmem_read : !pmem_write) || (pmem_address[31:5] != op_tag);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err <= 1'b0;
        end else if (viol) begin
            proto_err <= 1'b1;
        end
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: one instance with defaults (DEPTH=256, LATENCY=4) and one
// with DEPTH=4, LATENCY=1. Expected read data and response cycles come from a line model
// and are queued when a request is driven, then popped when the response appears.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    logic [31:0]  addr0 = '0, addr1 = '0;
    logic         rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [255:0] wd0 = '0, wd1 = '0;
    logic         resp0, resp1, perr0, perr1;
    logic [255:0] rdata0, rdata1;
    logic [1:0]   st0, st1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [255:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [255:0] ref_mem [int];
    logic [255:0] model_rdata [2] = '{default: '0};

`ifdef PMEM_PROTOCOL_CHECK_EN
    localparam logic EXP_BOTH_ERR = 1'b1;
`else
    localparam logic EXP_BOTH_ERR = 1'b0;
`endif

    pmem_line_responder #(.DEPTH(256), .LATENCY(4)) u_dut0 (
        .clk(clk), .rst(rst), .pmem_address(addr0), .pmem_read(rd0), .pmem_write(wr0),
        .pmem_wdata(wd0), .pmem_resp(resp0), .pmem_rdata(rdata0), .proto_err(perr0),
        .dbg_state(st0)
    );

    pmem_line_responder #(.DEPTH(4), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .pmem_address(addr1), .pmem_read(rd1), .pmem_write(wr1),
        .pmem_wdata(wd1), .pmem_resp(resp1), .pmem_rdata(rdata1), .proto_err(perr1),
        .dbg_state(st1)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one request, update the model, queue expectations, wait (bounded) for the
    // response, pop the expectations and release the request after the response edge.
    task automatic drive_op(input int sel, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [255:0] wd,
                            output logic [255:0] got_rdata, output int got_cyc,
                            output logic [255:0] exp_rdata, output int exp_cyc);
        int key;
        int lat;
        lat = (sel == 0) ? 4 : 1;
        key = sel * 1024 + ((sel == 0) ? int'(addr[12:5]) : int'(addr[6:5]));
        @(negedge clk);
        if (sel == 0) begin
            rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd;
        end else begin
            rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
        end
        if (rd) begin
            model_rdata[sel] = ref_mem.exists(key) ? ref_mem[key] : '0;
        end else if (wr) begin
            ref_mem[key] = wd;
        end
        exp_q.push_back(model_rdata[sel]);
        exp_cyc_q.push_back(cyc + lat);
        got_cyc   = -1;
        got_rdata = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((sel == 0) ? resp0 : resp1) begin
                got_cyc   = cyc;
                got_rdata = (sel == 0) ? rdata0 : rdata1;
                break;
            end
        end
        exp_rdata = exp_q.pop_front();
        exp_cyc   = exp_cyc_q.pop_front();
        @(posedge clk);
        #1;
        rd0 = 1'b0; wr0 = 1'b0; rd1 = 1'b0; wr1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (resp0 !== 1'b0) begin failures++; $display("FAIL reset_resp0 got=%b exp=0", resp0); end
        checks++; if (rdata0 !== '0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL reset_perr0 got=%b exp=0", perr0); end
        checks++; if (st0 !== 2'd0) begin failures++; $display("FAIL reset_state0 got=%0d exp=0", st0); end
        checks++; if (resp1 !== 1'b0) begin failures++; $display("FAIL reset_resp1 got=%b exp=0", resp1); end
        checks++; if (rdata1 !== '0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
        rst = 1'b0;
    endtask

    // Table of (read?, address, data) ops on the LATENCY=4 instance.
    task automatic test_write_read();
        logic [255:0] r, e;
        int c, ec;
        logic [31:0] a [4] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0100, 32'h0000_0040};
        logic        rd [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_op(0, rd[i], !rd[i], a[i], {32{8'hA5}}, r, c, e, ec);
            checks++; if (c !== ec) begin failures++; $display("FAIL wr_rd_%0d cycle got=%0d exp=%0d", i, c, ec); end
            checks++; if (r !== e) begin failures++; $display("FAIL wr_rd_%0d rdata got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_alias();
        logic [255:0] r, e;
        int c, ec;
        drive_op(0, 1'b0, 1'b1, 32'h0000_2000, {8{32'h1234_5678}}, r, c, e, ec);
        checks++; if (c !== ec) begin failures++; $display("FAIL alias_wr cycle got=%0d exp=%0d", c, ec); end
        drive_op(0, 1'b1, 1'b0, 32'h0000_0000, '0, r, c, e, ec);
        checks++; if (c !== ec) begin failures++; $display("FAIL alias_rd cycle got=%0d exp=%0d", c, ec); end
        checks++; if (r !== e) begin failures++; $display("FAIL alias_rd rdata got=%h exp=%h", r, e); end
    endtask

    // Random write/read pairs; the read uses different offset and upper alias bits.
    task automatic test_random();
        logic [255:0] r, e, d;
        int c, ec;
        logic [7:0] idx;
        for (int i = 0; i < 6; i++) begin
            idx = 8'($urandom_range(8, 255));
            for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
            drive_op(0, 1'b0, 1'b1, {19'($urandom()), idx, 5'($urandom())}, d, r, c, e, ec);
            checks++; if (r !== e) begin failures++; $display("FAIL rand_wr_%0d rdata got=%h exp=%h", i, r, e); end
            drive_op(0, 1'b1, 1'b0, {19'($urandom()), idx, 5'($urandom())}, '0, r, c, e, ec);
            checks++; if (c !== ec) begin failures++; $display("FAIL rand_rd_%0d cycle got=%0d exp=%0d", i, c, ec); end
            checks++; if (r !== e) begin failures++; $display("FAIL rand_rd_%0d rdata got=%h exp=%h", i, r, e); end
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] v, e;
        int c1, c2, ec;
        v = ref_mem.exists(2) ? ref_mem[2] : '0;
        model_rdata[0] = v;
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'h0000_0040;
        exp_q.push_back(v); exp_cyc_q.push_back(cyc + 4);
        exp_q.push_back(v); exp_cyc_q.push_back(cyc + 9);
        c1 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp0) begin c1 = cyc; break; end
        end
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        checks++; if (c1 !== ec) begin failures++; $display("FAIL b2b_first cycle got=%0d exp=%0d", c1, ec); end
        checks++; if (rdata0 !== e) begin failures++; $display("FAIL b2b_first rdata got=%h exp=%h", rdata0, e); end
        @(negedge clk);
        checks++; if (resp0 !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width got=%b exp=0", resp0); end
        c2 = -1;
        for (int i = 0; i < 20; i++) begin
            if (resp0) begin c2 = cyc; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        checks++; if (c2 !== ec) begin failures++; $display("FAIL b2b_second cycle got=%0d exp=%0d", c2, ec); end
        checks++; if (rdata0 !== e) begin failures++; $display("FAIL b2b_second rdata got=%h exp=%h", rdata0, e); end
        @(posedge clk);
        #1;
        rd0 = 1'b0;
    endtask

    task automatic test_reset_busy();
        logic [255:0] r, e;
        int c, ec;
        bit seen;
        drive_op(0, 1'b0, 1'b1, 32'h0000_0080, {16{16'hBEEF}}, r, c, e, ec);
        checks++; if (c !== ec) begin failures++; $display("FAIL rstbusy_old cycle got=%0d exp=%0d", c, ec); end
        @(negedge clk);
        wr0 = 1'b1; addr0 = 32'h0000_0080; wd0 = {16{16'hDEAD}};
        repeat (2) @(negedge clk);
        checks++; if (st0 !== 2'd1) begin failures++; $display("FAIL rstbusy_state got=%0d exp=1", st0); end
        rst = 1'b1; wr0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp0) seen = 1'b1;
            if (i == 0) rst = 1'b0;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstbusy_no_resp got=%b exp=0", seen); end
        model_rdata[0] = '0;
        drive_op(0, 1'b1, 1'b0, 32'h0000_0080, '0, r, c, e, ec);
        checks++; if (r !== e) begin failures++; $display("FAIL rstbusy_old_data got=%h exp=%h", r, e); end
        checks++; if (perr0 !== 1'b0) begin failures++; $display("FAIL clean_proto_err got=%b exp=0", perr0); end
    endtask

    task automatic test_both();
        logic [255:0] r, e;
        int c, ec;
        drive_op(0, 1'b1, 1'b1, 32'h0000_0040, {256{1'b1}}, r, c, e, ec);
        checks++; if (c !== ec) begin failures++; $display("FAIL both cycle got=%0d exp=%0d", c, ec); end
        checks++; if (r !== e) begin failures++; $display("FAIL both rdata got=%h exp=%h", r, e); end
        checks++; if (perr0 !== EXP_BOTH_ERR) begin failures++; $display("FAIL both_proto_err got=%b exp=%b", perr0, EXP_BOTH_ERR); end
        drive_op(0, 1'b1, 1'b0, 32'h0000_0040, '0, r, c, e, ec);
        checks++; if (r !== e) begin failures++; $display("FAIL both_unchanged got=%h exp=%h", r, e); end
    endtask

    // LATENCY=1, DEPTH=4 instance: write/read plus index alias at 0x80.
    task automatic test_latency1();
        logic [255:0] r, e;
        int c, ec;
        logic [31:0]  a  [4] = '{32'h0000_0020, 32'h0000_0020, 32'h0000_0080, 32'h0000_0000};
        logic         rd [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [255:0] d  [4] = '{{8{32'hCAFE_0001}}, '0, {8{32'h0BAD_F00D}}, '0};
        for (int i = 0; i < 4; i++) begin
            drive_op(1, rd[i], !rd[i], a[i], d[i], r, c, e, ec);
            checks++; if (c !== ec) begin failures++; $display("FAIL lat1_%0d cycle got=%0d exp=%0d", i, c, ec); end
            checks++; if (r !== e) begin failures++; $display("FAIL lat1_%0d rdata got=%h exp=%h", i, r, e); end
        end
        checks++; if (perr1 !== 1'b0) begin failures++; $display("FAIL lat1_proto_err got=%b exp=0", perr1); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_random();
        test_back_to_back();
        test_reset_busy();
        test_both();
        test_latency1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
